// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio PWM constants, state type and helpers
//
// Purpose: common definitions for the NCO -> PWM DAC path.
// Contents:
//   DEFAULT_CODE_WIDTH        NCO code / duty width
//   DEFAULT_CYCLES_PER_WINDOW PWM window length in clk cycles
//   dac_state_t               IDLE (parked) / RUN (windows running)
//   max_int                   elaboration-time max of two ints
package audio_pkg;

   localparam int DEFAULT_CODE_WIDTH        = 10;
   localparam int DEFAULT_CYCLES_PER_WINDOW = 1024;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } dac_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nco_pwm_dac_if.sv
// rtl/nco_pwm_dac_if.sv - NCO sample request/response interface
//
// Purpose: carries the sample code from the NCO and the advance request back.
// Signals:
//   code         NCO current sample (driven by the NCO)
//   next_sample  one-cycle advance request (driven by the consumer)
// Modports:
//   master  NCO side:      drives code, receives next_sample
//   slave   consumer side: receives code, drives next_sample
interface nco_pwm_dac_if #(
   parameter int CODE_WIDTH = audio_pkg::DEFAULT_CODE_WIDTH
) ();

   logic [CODE_WIDTH-1:0] code;
   logic                  next_sample;

   modport master (output code, input next_sample);
   modport slave  (input code, output next_sample);

endinterface

// File: rtl/pwm_window_counter.sv
// rtl/pwm_window_counter.sv - PWM window counter with request/last-cycle decode
//
// Purpose: holds the window position and decodes the strobes the top needs.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   en         run enable; low forces the counter back to 0
//   state      current top-level state (IDLE/RUN)
//   cnt_next   value cnt takes at the next edge
//   req_next   next_sample must be high in the next cycle
//   win_last   this cycle is the last cycle of a running window
module pwm_window_counter
   import audio_pkg::*;
#(
   parameter int CYCLES_PER_WINDOW = DEFAULT_CYCLES_PER_WINDOW,
   parameter int CNT_WIDTH         = $clog2(CYCLES_PER_WINDOW)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  dac_state_t           state,
   output logic [CNT_WIDTH-1:0] cnt_next,
   output logic                 req_next,
   output logic                 win_last
);

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CYCLES_PER_WINDOW - 1);
   localparam logic [CNT_WIDTH-1:0] REQ_CNT  = CNT_WIDTH'(CYCLES_PER_WINDOW - 2);

   logic [CNT_WIDTH-1:0] cnt;

   // Leaving IDLE starts a window at 0 rather than advancing, so the first
   // RUN cycle is always cnt=0.
   always_comb begin
      cnt_next = '0;
      if (en && (state == RUN) && (cnt != LAST_CNT)) begin
         cnt_next = cnt + CNT_WIDTH'(1);
      end
   end

   assign req_next = en && (cnt_next == REQ_CNT);
   assign win_last = (state == RUN) && (cnt == LAST_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/nco_pwm_dac.sv
// rtl/nco_pwm_dac.sv - fixed-rate PWM DAC pulling samples from an NCO
//
// Purpose: runs back-to-back PWM windows, requests one NCO sample per window
// and uses it as the duty of the following window.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               run enable; low parks the block in IDLE
//   nco              slave side of the NCO interface (code in, next_sample out)
//   pwm              registered PWM output
//   duty             currently latched duty
//   samples_fetched  number of next_sample pulses issued (wraps)
module nco_pwm_dac
   import audio_pkg::*;
#(
   parameter int CODE_WIDTH        = DEFAULT_CODE_WIDTH,
   parameter int CYCLES_PER_WINDOW = DEFAULT_CYCLES_PER_WINDOW,
   parameter int CNT_WIDTH         = $clog2(CYCLES_PER_WINDOW)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   nco_pwm_dac_if.slave          nco,
   output logic                  pwm,
   output logic [CODE_WIDTH-1:0] duty,
   output logic [15:0]           samples_fetched
);

   localparam int CMP_WIDTH = max_int(CODE_WIDTH, CNT_WIDTH);

   dac_state_t            state;
   logic [CNT_WIDTH-1:0]  cnt_next;
   logic                  req_next;
   logic                  win_last;
   logic                  next_sample_q;
   logic [CODE_WIDTH-1:0] duty_next;
   logic                  pwm_next;

   pwm_window_counter #(
      .CYCLES_PER_WINDOW (CYCLES_PER_WINDOW),
      .CNT_WIDTH         (CNT_WIDTH)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .state    (state),
      .cnt_next (cnt_next),
      .req_next (req_next),
      .win_last (win_last)
   );

   assign nco.next_sample = next_sample_q;

   // The window only completes if en is still high on its last edge; a window
   // cut short keeps the old duty.
   assign duty_next = (win_last && en) ? nco.code : duty;

   // Compare against next-cycle values so the registered pwm lines up with cnt.
   // Both sides are zero-extended, so duty beyond the window length is all-high.
   assign pwm_next = en && (CMP_WIDTH'(cnt_next) < CMP_WIDTH'(duty_next));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         duty            <= '0;
         pwm             <= 1'b0;
         next_sample_q   <= 1'b0;
         samples_fetched <= '0;
      end else begin
         case (state)
            IDLE:    state <= en ? RUN : IDLE;
            RUN:     state <= en ? RUN : IDLE;
            default: state <= IDLE;
         endcase
         duty            <= duty_next;
         pwm             <= pwm_next;
         next_sample_q   <= req_next;
         samples_fetched <= samples_fetched + 16'(next_sample_q);
      end
   end

endmodule

// File: tb/tb_nco_pwm_dac.sv
// tb/tb_nco_pwm_dac.sv - self-checking bench for nco_pwm_dac
module tb_nco_pwm_dac;
   import audio_pkg::*;

   localparam int CW = 10;
   localparam int NB = 1024;
   localparam int NS = 8;

   logic clk = 1'b0;
   logic rst;
   logic en;
   always #4 clk = ~clk;

   nco_pwm_dac_if #(.CODE_WIDTH(CW)) if_b ();
   nco_pwm_dac_if #(.CODE_WIDTH(CW)) if_s ();

   logic          pwm_b, pwm_s;
   logic [CW-1:0] duty_b, duty_s;
   logic [15:0]   sf_b, sf_s;

   nco_pwm_dac #(.CODE_WIDTH(CW), .CYCLES_PER_WINDOW(NB)) dut_b (
      .clk(clk), .rst(rst), .en(en), .nco(if_b.slave),
      .pwm(pwm_b), .duty(duty_b), .samples_fetched(sf_b));

   nco_pwm_dac #(.CODE_WIDTH(CW), .CYCLES_PER_WINDOW(NS)) dut_s (
      .clk(clk), .rst(rst), .en(en), .nco(if_s.slave),
      .pwm(pwm_s), .duty(duty_s), .samples_fetched(sf_s));

   // Reference: window position, duty and pending request tracked as plain ints.
   typedef struct {
      bit run;
      int pos;
      int duty;
      int fetched;
      bit ns;
      bit pwm;
   } mdl_t;

   mdl_t mb, ms;
   int   n_checks = 0;
   int   n_errors = 0;
   int   idx_b = 0, idx_s = 0;
   bit   adv_b = 0, adv_s = 0;
   int   hi_b = 0, hi_s = 0;
   int   win_b = 0;
   bit   dir_ok = 1;
   int   tbl_b [4] = '{512, 512, 0, 1023};
   int   dir_b [5] = '{0, 512, 512, 0, 1023};

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic mdl_t step(input mdl_t m, input bit e, input int code, input int n);
      mdl_t r = m;
      r.fetched = (m.fetched + (m.ns ? 1 : 0)) % 65536;
      if (!e) begin
         r.run = 0; r.pos = 0; r.ns = 0; r.pwm = 0;
      end else begin
         if (m.run && m.pos == n - 1) r.duty = code;
         r.pos = m.run ? (m.pos + 1) % n : 0;
         r.run = 1;
         r.ns  = (r.pos == n - 2);
         r.pwm = (r.pos < r.duty);
      end
      return r;
   endfunction

   function automatic mdl_t zero_mdl();
      mdl_t r;
      r.run = 0; r.pos = 0; r.duty = 0; r.fetched = 0; r.ns = 0; r.pwm = 0;
      return r;
   endfunction

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         mb = zero_mdl();
         ms = zero_mdl();
      end else begin
         mb = step(mb, en, int'(if_b.code), NB);
         ms = step(ms, en, int'(if_s.code), NS);
      end
      @(negedge clk);
      chk("b_pwm",  int'(pwm_b), int'(mb.pwm));
      chk("b_ns",   int'(if_b.next_sample), int'(mb.ns));
      chk("b_duty", int'(duty_b), mb.duty);
      chk("b_sf",   int'(sf_b), mb.fetched);
      chk("s_pwm",  int'(pwm_s), int'(ms.pwm));
      chk("s_ns",   int'(if_s.next_sample), int'(ms.ns));
      chk("s_duty", int'(duty_s), ms.duty);
      chk("s_sf",   int'(sf_s), ms.fetched);
      // high-time per complete window
      if (mb.run) begin
         if (mb.pos == 0) hi_b = 0;
         hi_b += int'(pwm_b);
         if (mb.pos == NB - 1) begin
            chk("b_win_hi", hi_b, min_int(mb.duty, NB));
            if (dir_ok && win_b < 5) chk("b_win_dir", hi_b, dir_b[win_b]);
            win_b++;
         end
      end else hi_b = 0;
      if (ms.run) begin
         if (ms.pos == 0) hi_s = 0;
         hi_s += int'(pwm_s);
         if (ms.pos == NS - 1) chk("s_win_hi", hi_s, min_int(ms.duty, NS));
      end else hi_s = 0;
      // stub NCOs advance on the edge that saw next_sample high
      if (adv_b) begin
         idx_b++;
         if (idx_b <= 4) if_b.code = CW'(tbl_b[idx_b - 1]);
         else if_b.code = CW'($urandom_range(0, (1 << CW) - 1));
      end
      if (adv_s) begin
         idx_s++;
         if_s.code = CW'(idx_s);
      end
      adv_b = mb.ns && !rst;
      adv_s = ms.ns && !rst;
   endtask

   initial begin
      int found;
      int duty_before;
      mb = zero_mdl();
      ms = zero_mdl();
      rst = 1'b1;
      en  = 1'b0;
      if_b.code = CW'(512);
      if_s.code = '0;
      repeat (3) cycle();

      // free-running windows: directed big codes, counting small stub
      rst = 1'b0;
      en  = 1'b1;
      repeat (80) cycle();
      chk("s_fetch10", int'(sf_s), 10);
      repeat (6 * NB) cycle();

      // en dropped at cnt=3 of a small window
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (ms.run && ms.pos == 3) found = 1;
         else cycle();
      end
      chk("drop_found", found, 1);
      dir_ok = 0;
      duty_before = ms.duty;
      en = 1'b0;
      cycle();
      chk("drop_duty", int'(duty_s), duty_before);
      chk("drop_pwm", int'(pwm_s), 0);
      chk("drop_ns", int'(if_s.next_sample), 0);
      repeat (3) cycle();
      en = 1'b1;
      cycle();
      chk("restart_duty", int'(duty_s), duty_before);
      repeat (40) cycle();

      // random enable activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         cycle();
      end

      // asynchronous reset while the small instance's pwm is high
      en = 1'b1;
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         if (ms.pwm) found = 1;
         else cycle();
      end
      chk("rst_setup", found, 1);
      chk("pre_rst_pwm", int'(pwm_s), 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_pwm_s",  int'(pwm_s), 0);
      chk("arst_ns_s",   int'(if_s.next_sample), 0);
      chk("arst_duty_s", int'(duty_s), 0);
      chk("arst_sf_s",   int'(sf_s), 0);
      chk("arst_pwm_b",  int'(pwm_b), 0);
      chk("arst_duty_b", int'(duty_b), 0);
      chk("arst_sf_b",   int'(sf_b), 0);
      mb = zero_mdl();
      ms = zero_mdl();
      adv_b = 0;
      adv_s = 0;
      repeat (2) cycle();
      rst = 1'b0;
      repeat (300) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/nco_pwm_dac.md
Name: nco_pwm_dac

Overview:
- Consumer end of the NCO sample interface.
- Generates a fixed-rate PWM window, pulses next_sample once per window to pull the next code from the NCO, and latches that code as the duty cycle of the following window.
- Sits between the nco and the board audio PWM pin.
- Replaces testbench-driven next_sample pulling with a periodic, deterministic request.

Parameters:
- CODE_WIDTH, 10, width of the NCO code / duty value.
- CYCLES_PER_WINDOW, 1024, PWM window length in clk cycles. Must be >= 4. Full scale is 2^CODE_WIDTH.
- CNT_WIDTH, $clog2(CYCLES_PER_WINDOW), width of the internal window counter.

Ports:
- clk  input  1  system clock (125 MHz on board).
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  run enable; low parks the block.
- code  input  CODE_WIDTH  current NCO output sample.
- next_sample  output  1  one-cycle request to the NCO to advance phase.
- pwm  output  1  registered PWM output.
- duty  output  CODE_WIDTH  currently latched duty, for debug/verification.
- samples_fetched  output  16  count of next_sample pulses issued; wraps at 65535 -> 0.

Behaviour:
- Reset (async, while rst=1):
  - cnt=0, duty=0, pwm=0, next_sample=0, samples_fetched=0, state=IDLE.
  - Release takes effect at the first clk edge with rst=0.
- States:
  - IDLE: en=0.
    - cnt held at 0; pwm=0; next_sample=0; duty retained.
    - IDLE->RUN on the first edge with en=1. That cycle begins window cnt=0 using the retained duty.
  - RUN:
    - cnt increments each edge; wraps CYCLES_PER_WINDOW-1 -> 0.
    - RUN->IDLE on the first edge with en=0. cnt, pwm and next_sample are 0 the following cycle, even mid-window or mid-request.
- Request timing (RUN only):
  - next_sample is a register, high exactly during the cycle where cnt == CYCLES_PER_WINDOW-2.
  - The NCO advances on that edge, so code is valid during cnt == CYCLES_PER_WINDOW-1.
  - duty <= code on the edge CYCLES_PER_WINDOW-1 -> 0. The new duty applies from cnt=0 of the next window.
  - The very first window after leaving IDLE uses the retained duty (0 after reset).
- samples_fetched increments on every edge where next_sample=1.
- PWM:
  - pwm is a flop loaded with (cnt_next < duty_next) and en_next, so during a cycle with counter value k, pwm == (k < duty).
  - Exactly duty high cycles per window, starting at cnt=0; no glitches.
  - Width rule: compare zero-extended to max(CODE_WIDTH, CNT_WIDTH).
  - duty >= CYCLES_PER_WINDOW gives pwm high the whole window. duty=0 gives pwm low the whole window.
- Simultaneous events:
  - rst dominates everything.
  - en falling in the same cycle as next_sample: the pulse already issued still counts; no further pulse.
  - duty is not updated, because the window never reaches its last cycle.
- code is sampled only on the duty-latch edge; changes at other times are ignored.

Decomposition:
- Shared package (audio_pkg): CODE_WIDTH=10, default CYCLES_PER_WINDOW=1024, and a state enum {IDLE, RUN}.
- One natural sub-module: pwm_window_counter, containing the cnt register, wrap logic, and the decoded request/last-cycle strobes.
- Duty latch, pwm compare and samples_fetched stay in the top.

Test Plan:
- Reset, then en=1, code=512, N=1024:
  - first window pwm all low (duty=0);
  - next_sample high at cnt=1022 only;
  - duty=512 from window 2;
  - 512 high / 512 low cycles per window thereafter.
- code=0 then code=1023, N=1024:
  - windows show 0 high cycles, then 1023 high + 1 low;
  - samples_fetched increments by 1 per window.
- N=8, stub NCO whose code = sample index (0,1,2,...), run 10 windows:
  - duty sequence 0,1,2,...;
  - pwm high count in window w equals w-1;
  - samples_fetched=10.
- N=8, code=9 (> window):
  - pwm high all 8 cycles;
  - no wrap or truncation artefacts.
- en dropped at cnt=3 of a window (N=8):
  - next cycle cnt=0, pwm=0, no next_sample, duty unchanged;
  - en re-raised: window restarts at cnt=0 with the old duty.
- rst asserted asynchronously mid-window with pwm=1:
  - pwm, next_sample, duty and samples_fetched go to 0 immediately, without waiting for clk;
  - normal operation resumes after release.
